// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer datapaths:
// controller state encoding, default widths and the output saturation helper.
package fc_pkg;

    localparam int FC_W         = 8;
    // Smallest accumulator that cannot wrap for 16 inputs of FC_W-bit operands.
    localparam int FC_ACC_WIDTH = 2 * FC_W + 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_DRAIN,
        ST_STORE,
        ST_DONE
    } fc_state_e;

    // Clamp a wide signed sum into the signed w-bit range.
    function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] acc,
                                                   input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi)
            return hi;
        else if (acc < lo)
            return lo;
        else
            return acc;
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Signed W x W multiplier feeding an ACC_WIDTH accumulator; clr has priority over en.
import fc_pkg::*;

module fc_mac_unit #(
    parameter int W         = FC_W,
    parameter int ACC_WIDTH = FC_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [W-1:0]         a,
    input  logic signed [W-1:0]         b,
    output logic signed [ACC_WIDTH-1:0] acc
);

    logic signed [2*W-1:0]       prod;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] acc_q;

    // Next accumulator value: clear, add sign-extended product, or hold.
    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = acc_q + {{(ACC_WIDTH - 2*W){prod[2*W-1]}}, prod};
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/fc_layer_seq_ctrl.sv
// Sequential FC-layer controller: one shared MAC walks OUT_SIZE neurons x IN_SIZE
// inputs, adds bias, saturates to W bits and stores each neuron result.
// Build option: define FC_CTRL_RELU_EN to clamp negative results to zero at store.
import fc_pkg::*;

module fc_layer_seq_ctrl #(
    parameter int IN_SIZE   = 16,
    parameter int OUT_SIZE  = 8,
    parameter int W         = FC_W,
    parameter int ACC_WIDTH = 2 * W + $clog2(IN_SIZE),
    localparam int AW       = $clog2(OUT_SIZE * IN_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [W*IN_SIZE-1:0]  in_vector_flat,
    input  logic [W*OUT_SIZE-1:0] biases_flat,
    output logic                  w_rd_en,
    output logic [AW-1:0]         w_addr,
    input  logic [W-1:0]          w_data,
    output logic [W*OUT_SIZE-1:0] out_vector_flat,
    output logic                  busy,
    output logic                  done
);

    localparam int JW = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
    localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    fc_state_e               state_q, state_d;
    logic [OW-1:0]           o_q, o_d;
    logic [JW-1:0]           j_q, j_d;
    logic [W*IN_SIZE-1:0]    x_q, x_d;
    logic [W*OUT_SIZE-1:0]   b_q, b_d;
    logic [W*OUT_SIZE-1:0]   out_q, out_d;
    logic [AW-1:0]           addr_hold_q, addr_hold_d;

    logic                    mac_clr;
    logic                    mac_en;
    logic [JW-1:0]           x_idx;
    logic signed [W-1:0]     x_sel;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [AW-1:0]           fetch_addr;
    logic signed [63:0]      sum64;
    logic [W-1:0]            res;

    fc_mac_unit #(
        .W         (W),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (x_sel),
        .b       ($signed(w_data)),
        .acc     (acc)
    );

    // Datapath: weight address, input operand aligned to the 1-cycle-late weight, store value.
    always_comb begin
        fetch_addr = AW'(o_q) * AW'(IN_SIZE) + AW'(j_q);
        // Weight returned now belongs to the previous j; in DRAIN j is parked on the last index.
        x_idx      = (state_q == ST_DRAIN) ? j_q : j_q - 1'b1;
        x_sel      = $signed(x_q[x_idx*W +: W]);
        sum64      = 64'(acc) + 64'($signed(b_q[o_q*W +: W]));
        res        = W'(sat_to_w(sum64, W));
`ifdef FC_CTRL_RELU_EN
        if (res[W-1])
            res = '0;
`endif
    end

    // Controller next-state and outputs.
    always_comb begin
        state_d     = state_q;
        o_d         = o_q;
        j_d         = j_q;
        x_d         = x_q;
        b_d         = b_q;
        out_d       = out_q;
        addr_hold_d = addr_hold_q;
        w_rd_en     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                busy    = 1'b1;
                x_d     = in_vector_flat;
                b_d     = biases_flat;
                o_d     = '0;
                j_d     = '0;
                mac_clr = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                busy        = 1'b1;
                w_rd_en     = 1'b1;
                addr_hold_d = fetch_addr;
                mac_en      = (j_q != '0);
                if (j_q == JW'(IN_SIZE - 1))
                    state_d = ST_DRAIN;
                else
                    j_d = j_q + 1'b1;
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                mac_en  = 1'b1;
                state_d = ST_STORE;
            end
            ST_STORE: begin
                busy                 = 1'b1;
                out_d[o_q*W +: W]    = res;
                mac_clr              = 1'b1;
                if (o_q == OW'(OUT_SIZE - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    o_d     = o_q + 1'b1;
                    j_d     = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, latched operands and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            o_q         <= '0;
            j_q         <= '0;
            x_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            addr_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            o_q         <= o_d;
            j_q         <= j_d;
            x_q         <= x_d;
            b_q         <= b_d;
            out_q       <= out_d;
            addr_hold_q <= addr_hold_d;
        end
    end

    assign w_addr          = w_rd_en ? fetch_addr : addr_hold_q;
    assign out_vector_flat = out_q;

endmodule

// File: tb/tb_fc_layer_seq_ctrl.sv
// Self-checking bench for fc_layer_seq_ctrl with a 1-cycle-latency weight RAM model.
module tb_fc_layer_seq_ctrl;

    localparam int IN_SIZE  = 16;
    localparam int OUT_SIZE = 8;
    localparam int W        = 8;
    localparam int NW       = IN_SIZE * OUT_SIZE;
    localparam int AW       = $clog2(NW);
    localparam int PER      = IN_SIZE + 2;
    localparam int LAT      = 2 + OUT_SIZE * PER;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic [W*IN_SIZE-1:0]  in_vector_flat = '0;
    logic [W*OUT_SIZE-1:0] biases_flat = '0;
    logic                  w_rd_en;
    logic [AW-1:0]         w_addr;
    logic [W-1:0]          w_data = '0;
    logic [W*OUT_SIZE-1:0] out_vector_flat;
    logic                  busy;
    logic                  done;

    int xs[IN_SIZE];
    int bs[OUT_SIZE];
    int ws[NW];

    int n_cmp = 0;
    int n_bad = 0;

    fc_layer_seq_ctrl #(
        .IN_SIZE  (IN_SIZE),
        .OUT_SIZE (OUT_SIZE),
        .W        (W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .in_vector_flat  (in_vector_flat),
        .biases_flat     (biases_flat),
        .w_rd_en         (w_rd_en),
        .w_addr          (w_addr),
        .w_data          (w_data),
        .out_vector_flat (out_vector_flat),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Synchronous weight RAM, one cycle read latency.
    always @(posedge clk)
        if (w_rd_en) w_data <= 8'(ws[w_addr]);

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int out_el(input int o);
        logic [W-1:0] v;
        v = out_vector_flat[o*W +: W];
        return int'($signed(v));
    endfunction

    task automatic drive_inputs();
        for (int j = 0; j < IN_SIZE; j++) in_vector_flat[j*W +: W] = 8'(xs[j]);
        for (int o = 0; o < OUT_SIZE; o++) biases_flat[o*W +: W] = 8'(bs[o]);
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // ---------------- behavioural model ----------------
    bit active = 0;
    int n = 0;
    int vis[OUT_SIZE];
    int pexp[OUT_SIZE];
    int last_addr = 0;
    int rd_seq = 0;

    function automatic bit is_fetch(input int c);
        return c >= 2 && (c - 2) / PER < OUT_SIZE && (c - 2) % PER < IN_SIZE;
    endfunction

    function automatic int fetch_addr(input int c);
        return ((c - 2) / PER) * IN_SIZE + (c - 2) % PER;
    endfunction

    function automatic int sat(input longint s);
        int r;
        r = (s > 127) ? 127 : (s < -128) ? -128 : int'(s);
`ifdef FC_CTRL_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        longint s;
        logic [W-1:0] v;
        if (!reset_n) begin
            active = 0;
            n = 0;
            last_addr = 0;
            for (int o = 0; o < OUT_SIZE; o++) vis[o] = 0;
        end else if (active) begin
            if (is_fetch(n)) last_addr = fetch_addr(n);
            if (n == 1) begin
                for (int o = 0; o < OUT_SIZE; o++) begin
                    s = 0;
                    for (int j = 0; j < IN_SIZE; j++) begin
                        v = in_vector_flat[j*W +: W];
                        s += longint'($signed(v)) * ws[o*IN_SIZE + j];
                    end
                    v = biases_flat[o*W +: W];
                    s += longint'($signed(v));
                    pexp[o] = sat(s);
                end
            end
            n++;
            if (n >= PER + 2 && (n - PER - 2) % PER == 0 && (n - PER - 2) / PER < OUT_SIZE)
                vis[(n - PER - 2) / PER] = pexp[(n - PER - 2) / PER];
            if (n > LAT) begin
                active = 0;
                n = 0;
            end
        end else if (start) begin
            active = 1;
            n = 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit exp_rd;
        exp_rd = active && is_fetch(n);
        chk("busy", int'(busy), int'(active && n <= LAT - 1));
        chk("done", int'(done), int'(active && n == LAT));
        chk("w_rd_en", int'(w_rd_en), int'(exp_rd));
        chk("w_addr", int'(w_addr), exp_rd ? fetch_addr(n) : last_addr);
        for (int o = 0; o < OUT_SIZE; o++)
            chk($sformatf("out[%0d]", o), out_el(o), vis[o]);
        if (active && n == 1) rd_seq = 0;
        if (w_rd_en) begin
            chk("addr_order", int'(w_addr), rd_seq);
            rd_seq++;
        end
        if (active && n == LAT) chk("reads_per_pass", rd_seq, NW);
    end

    // ---------------- stimulus ----------------
    task automatic set_scen1();
        int pat[4];
        pat[0] = 1; pat[1] = 1; pat[2] = -1; pat[3] = 0;
        for (int j = 0; j < IN_SIZE; j++) xs[j] = j + 1;
        for (int a = 0; a < NW; a++) ws[a] = pat[(a % IN_SIZE) % 4];
        for (int o = 0; o < OUT_SIZE; o++) bs[o] = -36 + 4 * o;
        drive_inputs();
    endtask

    task automatic check_scen1(input string tag);
        int e;
        for (int o = 0; o < OUT_SIZE; o++) begin
            e = -12 + 4 * o;
`ifdef FC_CTRL_RELU_EN
            if (e < 0) e = 0;
`endif
            chk($sformatf("%s_out[%0d]", tag, o), out_el(o), e);
        end
    endtask

    // Issue one start pulse, optionally scramble inputs after LOAD, wait for done.
    task automatic run_pass(input bit scramble, output int cyc);
        start = 1'b1;
        @(negedge clk); cyc = 1;
        start = 1'b0;
        @(negedge clk); cyc = 2;
        if (scramble) begin
            for (int j = 0; j < IN_SIZE; j++) xs[j] = rnd8();
            for (int o = 0; o < OUT_SIZE; o++) bs[o] = rnd8();
            drive_inputs();
        end
        while (!done && cyc < 400) begin
            @(negedge clk); cyc++;
        end
        chk("done_seen", int'(done), 1);
        chk("done_latency", cyc, LAT);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int pulses;
        int first_done;

        for (int a = 0; a < NW; a++) ws[a] = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(w_rd_en), 0);
        chk("rst_addr", int'(w_addr), 0);
        chk("rst_out", int'(out_vector_flat == '0), 1);
        reset_n = 1'b1;
        @(negedge clk);

        // Scenario 1 with input scrambling after LOAD
        set_scen1();
        run_pass(1'b1, cyc);
        check_scen1("s1");

        // Positive saturation
        for (int j = 0; j < IN_SIZE; j++) xs[j] = 127;
        for (int a = 0; a < NW; a++) ws[a] = 127;
        for (int o = 0; o < OUT_SIZE; o++) bs[o] = 127;
        drive_inputs();
        run_pass(1'b0, cyc);
        for (int o = 0; o < OUT_SIZE; o++) chk($sformatf("satp_out[%0d]", o), out_el(o), 127);

        // Negative saturation
        for (int a = 0; a < NW; a++) ws[a] = -128;
        run_pass(1'b0, cyc);
        for (int o = 0; o < OUT_SIZE; o++)
`ifdef FC_CTRL_RELU_EN
            chk($sformatf("satn_out[%0d]", o), out_el(o), 0);
`else
            chk($sformatf("satn_out[%0d]", o), out_el(o), -128);
`endif

        // Start pulse during a pass is ignored
        set_scen1();
        start = 1'b1;
        @(negedge clk); cyc = 1; start = 1'b0;
        pulses = 0; first_done = 0;
        while (cyc < 170) begin
            @(negedge clk); cyc++;
            start = (cyc == 50);
            if (done) begin
                pulses++;
                if (first_done == 0) first_done = cyc;
            end
        end
        start = 1'b0;
        chk("s4_done_pulses", pulses, 1);
        chk("s4_done_cycle", first_done, LAT);
        check_scen1("s4");

        // Mid-pass reset
        for (int j = 0; j < IN_SIZE; j++) xs[j] = rnd8();
        drive_inputs();
        start = 1'b1;
        @(negedge clk); cyc = 1; start = 1'b0;
        while (cyc < 70) begin @(negedge clk); cyc++; end
        #1 reset_n = 1'b0;
        #1;
        chk("s5_busy", int'(busy), 0);
        chk("s5_done", int'(done), 0);
        chk("s5_rd_en", int'(w_rd_en), 0);
        chk("s5_out", int'(out_vector_flat == '0), 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_scen1();
        run_pass(1'b0, cyc);
        check_scen1("s5");

        // Randomized passes
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < IN_SIZE; j++) xs[j] = rnd8();
            for (int a = 0; a < NW; a++) ws[a] = (k == 5) ? -128 : rnd8();
            for (int o = 0; o < OUT_SIZE; o++) bs[o] = rnd8();
            drive_inputs();
            run_pass(k[0], cyc);
        end

        // Start held across DONE: back-to-back passes
        for (int j = 0; j < IN_SIZE; j++) xs[j] = rnd8();
        for (int a = 0; a < NW; a++) ws[a] = rnd8();
        drive_inputs();
        start = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!done && cyc < 400);
        chk("b2b_first_done", cyc, LAT);
        for (int j = 0; j < IN_SIZE; j++) xs[j] = rnd8();
        for (int o = 0; o < OUT_SIZE; o++) bs[o] = rnd8();
        drive_inputs();
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!busy && cyc < 10);
        chk("b2b_restart_gap", cyc, 2);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin @(negedge clk); cyc++; end
        chk("b2b_second_done", cyc, LAT);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
